// File: rtl/dnn_seq_pkg.sv
// Shared constants and types for the DNN stream sequencer: word tags,
// field positions and the sequencer state encoding.
package dnn_seq_pkg;

    localparam int WORD_W = 32;

    // Tag field and chunk-length field positions inside a tagged word
    localparam int TAG_HI = 31;
    localparam int TAG_LO = 30;
    localparam int LEN_HI = 15;
    localparam int LEN_LO = 0;
    localparam int LEN_W  = LEN_HI - LEN_LO + 1;

    localparam logic [1:0] TAG_IDLE  = 2'd0;
    localparam logic [1:0] TAG_OP    = 2'd1;
    localparam logic [1:0] TAG_CHUNK = 2'd2;
    localparam logic [1:0] TAG_WAIT  = 2'd3;

    // Filler word driven while the host stalls or while draining outputs
    localparam logic [WORD_W-1:0] WAIT_WORD = {TAG_WAIT, {(WORD_W-2){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LEN,
        ST_OP,
        ST_CHUNK,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    function automatic logic [1:0] tag_of(input logic [WORD_W-1:0] w);
        return w[TAG_HI:TAG_LO];
    endfunction

    function automatic logic [LEN_W-1:0] len_of(input logic [WORD_W-1:0] w);
        return w[LEN_HI:LEN_LO];
    endfunction

endpackage

// File: rtl/seq_out_tracker.sv
// Tracks datapath outputs for the current job: remaining-output counter,
// over-count and reported-length mismatch checks, and the DRAIN timeout.
module seq_out_tracker
    import dnn_seq_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_len,
    input  logic              i_active,
    input  logic              i_drain,
    input  logic              i_y_valid,
    input  logic [WORD_W-1:0] i_out_count,
    input  logic              i_out_count_valid,
    output logic [WORD_W-1:0] o_outs_left,
    output logic              o_zero,
    output logic              o_err,
    output logic              o_timeout
);

    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);

    logic [WORD_W-1:0] r_outs;
    logic [WORD_W-1:0] r_len;
    logic [TW-1:0]     r_tmo;

    // Output counter: loaded with L at header, decremented per output, never wraps
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_outs <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_outs <= i_len;
            r_len  <= i_len;
        end else if (i_active && i_y_valid && (r_outs != '0)) begin
            r_outs <= r_outs - 1'b1;
        end
    end

    // Drain watchdog: counts DRAIN cycles since the last output
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_tmo <= '0;
        end else if (!i_drain || i_y_valid) begin
            r_tmo <= '0;
        end else if (r_tmo != TMO_LAST) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign o_outs_left = r_outs;
    assign o_zero      = (r_outs == '0);
    // The final idle DRAIN cycle raises the flag so the abort lands on the
    // DRAIN_TIMEOUT-th edge spent in DRAIN.
    assign o_timeout   = i_drain && !i_y_valid && (r_tmo == TMO_LAST);
    assign o_err       = i_active && ((i_y_valid && (r_outs == '0)) ||
                                      (i_out_count_valid && (i_out_count != r_len)));

endmodule

// File: rtl/dnn_stream_sequencer.sv
// Host-side job sequencer: parses the header, checks tags on the command
// stream, forwards words to the datapath with enable, inserts filler on
// stalls and waits for the expected number of datapath outputs.
module dnn_stream_sequencer
    import dnn_seq_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] dp_data,
    output logic              dp_enable,
    input  logic              dp_y_valid,
    input  logic [WORD_W-1:0] dp_out_count,
    input  logic              dp_out_count_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] ops_left,
    output logic [WORD_W-1:0] outs_left
);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [WORD_W-1:0] r_dp_data;
    logic              r_dp_en;
    logic [WORD_W-1:0] w_dp_data;
    logic              w_dp_en;
    logic [WORD_W-1:0] r_ops;
    logic [LEN_W-1:0]  r_chunk;
    logic              r_err;

    logic              w_acc;
    logic [1:0]        w_tag;
    logic [LEN_W-1:0]  w_clen;
    logic              w_hdr_ok;
    logic              w_op_done;
    logic              w_last;
    logic              w_bad;
    logic              w_trk_zero;
    logic              w_trk_err;
    logic              w_trk_tmo;
    logic              w_tmo_abort;
    logic              w_err_set;

    assign s_ready = (r_state == ST_IDLE) || (r_state == ST_HDR_LEN) ||
                     (r_state == ST_OP)   || (r_state == ST_CHUNK);
    assign w_acc   = s_valid && s_ready;
    assign w_tag   = tag_of(s_data);
    assign w_clen  = len_of(s_data);

    // A zero op count is rejected rather than starting a job
    assign w_hdr_ok  = (r_state == ST_IDLE) && w_acc && (s_data != '0);
    assign w_op_done = ((r_state == ST_OP)    && w_acc && (w_tag == TAG_OP) && (w_clen == '0)) ||
                       ((r_state == ST_CHUNK) && w_acc && (w_tag == TAG_CHUNK) && (r_chunk == LEN_W'(1)));
    assign w_last    = w_op_done && (r_ops == WORD_W'(1));
    assign w_bad     = ((r_state == ST_OP)    && w_acc && (w_tag != TAG_OP)    && (w_tag != TAG_WAIT)) ||
                       ((r_state == ST_CHUNK) && w_acc && (w_tag != TAG_CHUNK) && (w_tag != TAG_WAIT));
    // Completion wins over a coincident watchdog expiry
    assign w_tmo_abort = w_trk_tmo && !w_trk_zero;
    assign w_err_set   = ((r_state == ST_IDLE) && w_acc && (s_data == '0)) ||
                         w_bad || w_trk_err || w_tmo_abort;

    seq_out_tracker #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) u_trk (
        .clk               (clk),
        .clear             (clear),
        .i_load            ((r_state == ST_HDR_LEN) && w_acc),
        .i_len             (s_data),
        .i_active          ((r_state == ST_OP) || (r_state == ST_CHUNK) || (r_state == ST_DRAIN)),
        .i_drain           (r_state == ST_DRAIN),
        .i_y_valid         (dp_y_valid),
        .i_out_count       (dp_out_count),
        .i_out_count_valid (dp_out_count_valid),
        .o_outs_left       (outs_left),
        .o_zero            (w_trk_zero),
        .o_err             (w_trk_err),
        .o_timeout         (w_trk_tmo)
    );

    // State register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_hdr_ok) w_next = ST_HDR_LEN;
            ST_HDR_LEN: if (w_acc) w_next = ST_OP;
            ST_OP: begin
                if (w_bad)                           w_next = ST_IDLE;
                else if (w_op_done)                  w_next = w_last ? ST_DRAIN : ST_OP;
                else if (w_acc && w_tag == TAG_OP)   w_next = ST_CHUNK;
            end
            ST_CHUNK: begin
                if (w_bad)          w_next = ST_IDLE;
                else if (w_op_done) w_next = w_last ? ST_DRAIN : ST_OP;
            end
            ST_DRAIN: begin
                if (w_trk_zero)     w_next = ST_DONE;
                else if (w_trk_tmo) w_next = ST_IDLE;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Output logic: word/enable to register for next cycle, status from state
    always_comb begin
        w_dp_data = '0;
        w_dp_en   = 1'b0;
        busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done      = (r_state == ST_DONE);
        unique case (r_state)
            ST_IDLE: begin
                if (w_hdr_ok) begin
                    w_dp_data = s_data;
                    w_dp_en   = 1'b1;
                end
            end
            ST_HDR_LEN, ST_OP, ST_CHUNK: begin
                if (!s_valid) begin
                    w_dp_data = WAIT_WORD;
                    w_dp_en   = 1'b1;
                end else if (!w_bad) begin
                    w_dp_data = s_data;
                    w_dp_en   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_next == ST_DRAIN) begin
                    w_dp_data = WAIT_WORD;
                    w_dp_en   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered datapath drive: accepted word shows up one cycle later
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_dp_data <= '0;
            r_dp_en   <= 1'b0;
        end else begin
            r_dp_data <= w_dp_data;
            r_dp_en   <= w_dp_en;
        end
    end

    // Operation and chunk counters
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_ops   <= '0;
            r_chunk <= '0;
        end else begin
            if (w_hdr_ok)       r_ops <= s_data;
            else if (w_op_done) r_ops <= r_ops - 1'b1;

            if ((r_state == ST_OP) && w_acc && (w_tag == TAG_OP))
                r_chunk <= w_clen;
            else if ((r_state == ST_CHUNK) && w_acc && (w_tag == TAG_CHUNK))
                r_chunk <= r_chunk - 1'b1;
        end
    end

    // Sticky error, cleared only when a valid header starts a new job
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)         r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
        else if (w_hdr_ok)  r_err <= 1'b0;
    end

    assign dp_data  = r_dp_data;
    assign dp_enable = r_dp_en;
    assign err      = r_err;
    assign ops_left = r_ops;

endmodule
